pipe_ctrl: RTL and testbench

Parametrised pipeline controller that arbitrates branch/jump redirects from the execute stage against multi-cycle hold requests from units such as the divider and the bus interface. It drives the PC redirect, per-stage pause flags and per-stage flush flags. It sits between ex, pc_reg and the pipeline registers (if_id, id_ex, …). A jump raised while the pipeline is held is latched and replayed when the hold releases, so no redirect is lost. A watchdog flags holds that exceed a programmed bound.

---
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between ex / hold requesters and the pipeline controller.
// The slave modport is the controller side; master is the requesting environment.
interface pipe_ctrl_if #(
    parameter int STAGES = 3,
    parameter int ADDR_W = 32,
    parameter int NHOLD  = 2
);
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic [NHOLD-1:0]  hold_req_i;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic [STAGES-1:0] pause_flag_o;
    logic [STAGES-1:0] flush_flag_o;
    logic              hold_timeout_o;
    logic              busy_o;

    modport master (
        output jump_flag_i, jump_addr_i, hold_req_i,
        input  jump_flag_o, jump_addr_o, pause_flag_o, flush_flag_o,
               hold_timeout_o, busy_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_req_i,
        output jump_flag_o, jump_addr_o, pause_flag_o, flush_flag_o,
               hold_timeout_o, busy_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates ex redirects against multi-cycle holds,
// replaying a jump captured during a hold once the hold releases.
module pipe_ctrl #(
    parameter int STAGES   = 3,
    parameter int ADDR_W   = 32,
    parameter int NHOLD    = 2,
    parameter int HOLD_MAX = 255
) (
    input logic      clk,
    input logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0]     CNT_MAX   = CW'(HOLD_MAX);
    localparam bit                WD_EN     = (HOLD_MAX != 0);
    localparam logic [STAGES-1:0] FLUSH_ALL = ~STAGES'(1);
    localparam logic [STAGES-1:0] PAUSE_ALL = '1;

    typedef enum logic [1:0] {IDLE, HOLD, REPLAY} state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_pendVld;
    logic [ADDR_W-1:0] r_pendAddr;
    logic [CW-1:0]     r_holdCnt;
    logic              r_timeout;
    logic              w_holdAny;
    logic              w_capture;
    logic              w_pendAfter;

    assign w_holdAny = |bus.hold_req_i;

    // The first jump seen while held (or on the hold-entry cycle) is kept.
    assign w_capture   = bus.jump_flag_i & ~r_pendVld &
                         ((r_state == HOLD) | ((r_state == IDLE) & w_holdAny));
    assign w_pendAfter = r_pendVld | w_capture;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_holdAny) w_stateNext = HOLD;
            HOLD:    if (!w_holdAny) w_stateNext = w_pendAfter ? REPLAY : IDLE;
            REPLAY:  w_stateNext = w_holdAny ? HOLD : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pendVld  <= 1'b0;
            r_pendAddr <= '0;
            r_holdCnt  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == REPLAY) begin
                r_pendVld <= 1'b0;
            end else if (w_capture) begin
                r_pendVld  <= 1'b1;
                r_pendAddr <= bus.jump_addr_i;
            end
            if ((r_state == HOLD) && (w_stateNext == HOLD))
                r_holdCnt <= (r_holdCnt == CNT_MAX) ? r_holdCnt : r_holdCnt + CW'(1);
            else
                r_holdCnt <= '0;
            // Sticky until reset; the hold itself is never released by it.
            if (WD_EN && (r_state == HOLD) && (r_holdCnt == CNT_MAX))
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        bus.jump_flag_o  = 1'b0;
        bus.jump_addr_o  = '0;
        bus.pause_flag_o = '0;
        bus.flush_flag_o = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_holdAny) begin
                        bus.pause_flag_o = PAUSE_ALL;
                    end else begin
                        bus.jump_flag_o  = bus.jump_flag_i;
                        bus.jump_addr_o  = bus.jump_addr_i;
                        bus.flush_flag_o = bus.jump_flag_i ? FLUSH_ALL : '0;
                    end
                end
                HOLD: bus.pause_flag_o = PAUSE_ALL;
                REPLAY: begin
                    bus.jump_flag_o  = 1'b1;
                    bus.jump_addr_o  = r_pendAddr;
                    bus.flush_flag_o = FLUSH_ALL;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o         = ~rst & ((r_state != IDLE) | r_pendVld);
    assign bus.hold_timeout_o = r_timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_pipe_ctrl;
    localparam int STAGES   = 3;
    localparam int ADDR_W   = 32;
    localparam int NHOLD    = 2;
    localparam int HOLD_MAX = 8;

    logic clk;
    logic rst;
    int   checksTotal;
    int   checksPassed;

    pipe_ctrl_if #(.STAGES(STAGES), .ADDR_W(ADDR_W), .NHOLD(NHOLD)) ifc ();

    pipe_ctrl #(
        .STAGES(STAGES), .ADDR_W(ADDR_W), .NHOLD(NHOLD), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: held or not, a one-shot replay marker, and a queue holding the pending target.
    bit          mHolding;
    bit          mReplayNow;
    logic [31:0] pendQ[$];
    int          holdCycles;
    bit          mTimeout;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksTotal++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        else
            checksPassed++;
    endtask

    task automatic modelReset();
        mHolding   = 1'b0;
        mReplayNow = 1'b0;
        pendQ.delete();
        holdCycles = 0;
        mTimeout   = 1'b0;
    endtask

    task automatic applyStimulus(input bit rstV, input bit jf, input logic [31:0] ja, input logic [1:0] hr);
        bit          eJump;
        logic [31:0] eAddr;
        logic [2:0]  ePause;
        logic [2:0]  eFlush;
        bit          eBusy;
        bit          addrKnown;
        bit          holdAny;
        @(negedge clk);
        rst             = rstV;
        ifc.jump_flag_i = jf;
        ifc.jump_addr_i = ja;
        ifc.hold_req_i  = hr;
        #1;
        holdAny   = |hr;
        eJump     = 1'b0;
        eAddr     = '0;
        ePause    = '0;
        eFlush    = '0;
        eBusy     = 1'b0;
        addrKnown = 1'b1;
        if (rstV) begin
        end else if (mReplayNow) begin
            eJump  = 1'b1;
            eAddr  = pendQ[0];
            eFlush = 3'b110;
            eBusy  = 1'b1;
        end else if (mHolding) begin
            ePause    = 3'b111;
            eBusy     = 1'b1;
            addrKnown = 1'b0;
        end else if (holdAny) begin
            ePause    = 3'b111;
            addrKnown = 1'b0;
        end else begin
            eJump  = jf;
            eAddr  = ja;
            eFlush = jf ? 3'b110 : 3'b000;
        end
        checkOutput("jump_flag", 64'(ifc.jump_flag_o), 64'(eJump));
        if (addrKnown) checkOutput("jump_addr", 64'(ifc.jump_addr_o), 64'(eAddr));
        checkOutput("pause", 64'(ifc.pause_flag_o), 64'(ePause));
        checkOutput("flush", 64'(ifc.flush_flag_o), 64'(eFlush));
        checkOutput("busy", 64'(ifc.busy_o), 64'(eBusy));
        checkOutput("timeout", 64'(ifc.hold_timeout_o), 64'(rstV ? 1'b0 : mTimeout));
        @(posedge clk);
        if (rstV) begin
            modelReset();
        end else if (mReplayNow) begin
            void'(pendQ.pop_front());
            mReplayNow = 1'b0;
            mHolding   = holdAny;
            holdCycles = 0;
        end else if (mHolding) begin
            if (jf && pendQ.size() == 0) pendQ.push_back(ja);
            if (HOLD_MAX != 0 && holdCycles == HOLD_MAX) mTimeout = 1'b1;
            if (holdAny) begin
                holdCycles = (holdCycles < HOLD_MAX) ? holdCycles + 1 : HOLD_MAX;
            end else begin
                mHolding   = 1'b0;
                holdCycles = 0;
                mReplayNow = (pendQ.size() > 0);
            end
        end else if (holdAny) begin
            mHolding   = 1'b1;
            holdCycles = 0;
            if (jf) pendQ.push_back(ja);
        end
    endtask

    initial begin
        logic [1:0]  hr;
        checksTotal     = 0;
        checksPassed    = 0;
        rst             = 1'b1;
        ifc.jump_flag_i = 1'b0;
        ifc.jump_addr_i = '0;
        ifc.hold_req_i  = '0;
        modelReset();

        // Outputs must be forced low during reset even with active inputs.
        applyStimulus(1, 1, 32'h0000_0100, 2'b00);
        applyStimulus(1, 1, 32'h0000_0104, 2'b11);

        applyStimulus(0, 1, 32'h0000_0100, 2'b00);
        applyStimulus(0, 0, 32'h0000_0000, 2'b00);

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 2'b01);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 2'b00);

        for (int i = 0; i < 5; i++)
            applyStimulus(0, i >= 2, (i == 2) ? 32'h200 : 32'h204, 2'b10);
        applyStimulus(0, 1, 32'h204, 2'b00);
        applyStimulus(0, 1, 32'h204, 2'b00);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 2'b00);

        // Replay with the hold reasserted in the replay cycle.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h300, 2'b01);
        applyStimulus(0, 0, 32'h0, 2'b00);
        applyStimulus(0, 1, 32'h300, 2'b01);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 32'h0, 2'b01);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 2'b00);

        // Reset mid-hold discards the pending jump.
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 32'h400, 2'b01);
        applyStimulus(1, 0, 32'h0, 2'b01);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 2'b00);

        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 32'h0, 2'b01);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 2'b00);
        applyStimulus(1, 0, 32'h0, 2'b00);
        applyStimulus(0, 0, 32'h0, 2'b00);

        hr = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0)
                hr = ($urandom_range(9) < 4) ? 2'($urandom_range(3)) : 2'b00;
            applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 3, $urandom, hr);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
